mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and sequences a fixed-latency busy window.
- Owns the HI/LO registers.
- Raises a stall request so a dependent md instruction in D waits until the unit is free.

Parameters:
- MUL_CYCLES, 5, busy cycles for multiply ops (legal 1..15)
- DIV_CYCLES, 10, busy cycles for divide ops (legal 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage md instruction valid this cycle
- op  in  4  operation code (MDU_* constants)
- a  in  32  rs operand
- b  in  32  rt operand
- d_md_use  in  1  D-stage instruction is any md op (incl. MFHI/MFLO)
- busy  out  1  arithmetic op in flight
- stall  out  1  pipeline stall request to D/F
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9..15 are treated as NONE.
- Reset (reset==0, any time, asynchronous): state IDLE, count 0, busy 0, hi 0, lo 0, pending result discarded.
  - Reset mid-operation aborts the op; nothing is committed.
- States:
  - IDLE: start with an arithmetic op → latch operands, compute the 64-bit result into internal regs, load count=MUL_CYCLES or DIV_CYCLES, go to BUSY.
  - IDLE: start with MTHI → hi<=a at the same edge; MTLO → lo<=a; stay IDLE, busy stays 0.
  - BUSY: count decrements each edge. On the edge where count==1, commit {hi,lo}, set count to 0, return to IDLE.
- busy is registered: high for exactly N cycles starting the cycle after the start edge.
- hi/lo hold their old values throughout BUSY.
- stall = d_md_use & (busy | (start & op is arithmetic or MT*)). Combinational, no state.
- start while BUSY is a protocol violation: ignore it, with no state change (bench asserts it never happens).
- MULT: signed 32x32 product, hi=upper word, lo=lower word. MULTU: unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0): busy window still runs DIV_CYCLES; hi/lo are left unchanged at commit.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MADD/MADDU set {hi,lo} <= {hi,lo} + signed/unsigned product (mod 2^64).
  - Uses MUL_CYCLES latency; hi/lo are sampled at start.
- Undefined: ops 7/8 behave as NONE (no busy, no state change), and stall ignores them.

Decomposition:
- Shared defines file mdu_defs: MDU_* op codes, MDU_OP_W=4, and the is-arithmetic/is-MT decode macros.
  - The decoder and hazard unit include the same file.
- One sub-module, mdu_arith: purely combinational signed/unsigned multiply and divide producing {hi_n, lo_n}, plus the div-by-zero flag.
- The controller FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- Reset release, no start → busy=0, stall=0, hi=lo=0. Assert reset=0 mid-DIV → hi/lo return to 0 immediately and busy=0.
- MULT a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → hi/lo unchanged after 10 cycles.
- MTHI a=0x12345678 → hi=0x12345678 on the next edge, busy never rises. d_md_use=1 during start, and during each busy cycle of a MULT → stall=1; stall=0 the cycle busy falls.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. A start pulse injected during BUSY → ignored; the original result is committed.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro, the same stimulus → no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e  : MDU_* operation codes carried on the 4-bit op bus
//   - MDU_OP_W  : op bus width
//   - mdu_is_*  : op-class decode helpers shared by the controller,
//                 the arithmetic block and the hazard logic
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU; when undefined
// ops 7/8 decode as NONE).
package mdu_ctrl_pkg;

  localparam int unsigned MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  function automatic logic mdu_is_madd(input logic [MDU_OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MADD) || (op == MDU_MADDU);
`else
    return (op == MDU_MADD) && 1'b0;
`endif
  endfunction

  function automatic logic mdu_is_mul(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || mdu_is_madd(op);
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_arith(input logic [MDU_OP_W-1:0] op);
    return mdu_is_mul(op) || mdu_is_div(op);
  endfunction

  function automatic logic mdu_is_mt(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

  function automatic logic mdu_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath.
//   op           in  4   operation code (MDU_*)
//   a, b         in  32  rs / rt operands
//   acc_hi/lo    in  32  current HI/LO, accumulated by MADD/MADDU
//   hi_n, lo_n   out 32  result words ({hi,lo} for mul, {rem,quot} for div)
//   div_zero     out 1   divide op with b == 0 (result must not be committed)
// Optional feature macro: MDU_MADD_EN (via mdu_is_madd).
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [31:0]         acc_hi,
  input  logic [31:0]         acc_lo,
  output logic [31:0]         hi_n,
  output logic [31:0]         lo_n,
  output logic                div_zero
);

  logic        sgn, neg_a, neg_b;
  logic [63:0] ma, mb, prod, mul_res;
  logic [31:0] abs_a, abs_b, divisor, q, r, quot, rem;

  always_comb begin
    sgn   = mdu_is_signed(op);
    ma    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    mb    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ma * mb;
    mul_res = mdu_is_madd(op) ? (prod + {acc_hi, acc_lo}) : prod;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to
    // 0x80000000 instead of hitting an overflowing signed divide.
    neg_a   = sgn & a[31];
    neg_b   = sgn & b[31];
    abs_a   = neg_a ? (~a + 32'd1) : a;
    abs_b   = neg_b ? (~b + 32'd1) : b;
    div_zero = mdu_is_div(op) && (b == '0);
    divisor = (b == '0) ? 32'd1 : abs_b;
    q       = abs_a / divisor;
    r       = abs_a % divisor;
    quot    = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
    rem     = neg_a ? (~r + 32'd1) : r;

    if (mdu_is_div(op)) begin
      hi_n = rem;
      lo_n = quot;
    end else begin
      hi_n = mul_res[63:32];
      lo_n = mul_res[31:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the E stage.
// Owns HI/LO, sequences a fixed-latency busy window per arithmetic op and
// raises a stall for dependent md instructions in D.
//   clk       in  1   system clock, rising edge
//   reset     in  1   asynchronous active-low reset
//   start     in  1   E-stage md instruction valid
//   op        in  4   operation code (MDU_*)
//   a, b      in  32  rs / rt operands
//   d_md_use  in  1   D-stage instruction is an md op
//   busy      out 1   arithmetic op in flight (registered)
//   stall     out 1   stall request to D/F
//   hi, lo    out 32  HI / LO registers
// Parameters: MUL_CYCLES, DIV_CYCLES (1..15).
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic                d_md_use,
  output logic                busy,
  output logic                stall,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        res_wr_q, res_wr_d;

  logic [31:0] hi_n, lo_n;
  logic        div_zero;

  mdu_arith u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .acc_hi   (hi_q),
    .acc_lo   (lo_q),
    .hi_n     (hi_n),
    .lo_n     (lo_n),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_wr_d = res_wr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mdu_is_arith(op)) begin
            // Result is computed now and held until the commit edge.
            res_d    = {hi_n, lo_n};
            res_wr_d = ~div_zero;
            count_d  = mdu_is_div(op) ? DIV_CNT : MUL_CNT;
            state_d  = ST_BUSY;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_BUSY: begin
        if (count_q == 4'd1) begin
          if (res_wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = d_md_use & (busy_q | (start & (mdu_is_arith(op) | mdu_is_mt(op))));

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use, busy, stall;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op = MDU_MTHI; a = h;
    tick();
    op = MDU_MTLO; a = l;
    tick();
    start = 1'b0; op = MDU_NONE;
  endtask

  // Issue one op and follow it to completion; operands are scrambled after
  // the start edge so the unit must have captured them.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    logic [31:0] ph, pl;
    logic        hold_ok;
    int          n;
    ph = hi; pl = lo; hold_ok = 1'b1; n = 0;
    start = 1'b1; op = o; a = va; b = vb;
    tick();
    start = 1'b0; op = MDU_NONE; a = $urandom; b = $urandom;
    while (busy && n < 40) begin
      n++;
      if (hi !== ph || lo !== pl) hold_ok = 1'b0;
      tick();
    end
    chk({name, " cycles"}, 64'(n), 64'(ecyc));
    chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
    if (ecyc > 0) chk({name, " hold"}, {63'd0, hold_ok}, 64'd1);
  endtask

  // Reference model from the arithmetic definitions, using 64-bit integers.
  task automatic model(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] h_in, input logic [31:0] l_in,
                       output logic [31:0] h, output logic [31:0] l, output int cyc);
    logic [63:0] p;
    longint      sa, sb, q, r;
    h = h_in; l = l_in; cyc = 0;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    case (o)
      4'd1: begin p = sa * sb; {h, l} = p; cyc = 5; end
      4'd2: begin p = {32'd0, va} * {32'd0, vb}; {h, l} = p; cyc = 5; end
      4'd3: begin
        cyc = 10;
        if (vb != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      4'd4: begin
        cyc = 10;
        if (vb != 0) begin l = va / vb; h = va % vb; end
      end
      4'd5: h = va;
      4'd6: l = va;
`ifdef MDU_MADD_EN
      4'd7: begin p = sa * sb; {h, l} = {h_in, l_in} + p; cyc = 5; end
      4'd8: begin p = {32'd0, va} * {32'd0, vb}; {h, l} = {h_in, l_in} + p; cyc = 5; end
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick(input int zero_pct);
    int unsigned sel;
    sel = $urandom_range(0, 99);
    if (sel < 32'(zero_pct)) return '0;
    if (sel < 40) return $urandom_range(0, 20);
    if (sel < 50) return 32'hFFFF_FFFF - $urandom_range(0, 20);
    if (sel < 55) return 32'h8000_0000;
    return $urandom;
  endfunction

  initial begin
    logic [31:0] eh, el;
    int          ec, n;
    logic        flag;

    reset = 1'b0; start = 1'b0; op = MDU_NONE; a = '0; b = '0; d_md_use = 1'b0;
    tick(); tick();
    reset = 1'b1;
    d_md_use = 1'b1;
    tick(); tick();
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    d_md_use = 1'b0;

    vecs.push_back('{"mult_neg", MDU_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{"multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back('{"mult_min", MDU_MULT, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, 5});
    vecs.push_back('{"div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFD, 10});
    vecs.push_back('{"div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 5, 5, 32'h0, 32'h80000000, 10});
    vecs.push_back('{"divu", MDU_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 10});
    vecs.push_back('{"divu_zero", MDU_DIVU, 32'd7, 32'd0, 32'hAAAA5555, 32'h1234, 32'hAAAA5555, 32'h1234, 10});
    vecs.push_back('{"mthi", MDU_MTHI, 32'h12345678, 32'd9, 0, 0, 32'h12345678, 32'h0, 0});
    vecs.push_back('{"mtlo", MDU_MTLO, 32'hCAFEF00D, 32'd9, 32'h11, 0, 32'h11, 32'hCAFEF00D, 0});
    vecs.push_back('{"none", MDU_NONE, 32'd3, 32'd3, 32'd5, 32'd6, 32'd5, 32'd6, 0});
    vecs.push_back('{"op12", 4'd12, 32'd3, 32'd3, 32'd5, 32'd6, 32'd5, 32'd6, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{"maddu", MDU_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5});
    vecs.push_back('{"madd", MDU_MADD, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5});
`else
    vecs.push_back('{"maddu", MDU_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 0});
    vecs.push_back('{"madd", MDU_MADD, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0, 0});
`endif

    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);
    end

    // Stall: combinational on start, then held through busy, drops with busy.
    d_md_use = 1'b1;
    start = 1'b1; op = MDU_NONE; #1;
    chk("stall none", {63'd0, stall}, 64'd0);
    op = MDU_MTHI; #1;
    chk("stall mthi", {63'd0, stall}, 64'd1);
    op = MDU_MADDU; #1;
`ifdef MDU_MADD_EN
    chk("stall maddu", {63'd0, stall}, 64'd1);
`else
    chk("stall maddu", {63'd0, stall}, 64'd0);
`endif
    start = 1'b0; op = MDU_NONE;
    tick();
    start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd3; #1;
    chk("stall start", {63'd0, stall}, 64'd1);
    tick();
    start = 1'b0; op = MDU_NONE;
    flag = 1'b1; n = 0;
    while (busy && n < 40) begin
      n++;
      if (!stall) flag = 1'b0;
      tick();
    end
    chk("stall busy", {63'd0, flag}, 64'd1);
    chk("stall busy cycles", 64'(n), 64'd5);
    chk("stall after", {63'd0, stall}, 64'd0);

    // d_md_use low: no stall even while busy.
    d_md_use = 1'b0;
    start = 1'b1; op = MDU_MULTU; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; op = MDU_NONE;
    chk("nostall busy", {62'd0, busy, stall}, 64'd2);
    repeat (6) tick();

    // Start pulse during BUSY is ignored; original DIVU result commits.
    set_hilo(0, 0);
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = MDU_NONE;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd3; end
      else begin start = 1'b0; op = MDU_NONE; end
      tick();
    end
    start = 1'b0; op = MDU_NONE;
    chk("inject cycles", 64'(n), 64'd10);
    chk("inject hilo", {hi, lo}, {32'd2, 32'd14});
    tick();
    chk("inject idle", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-DIV: clears immediately, nothing commits later.
    set_hilo(32'hDEAD, 32'hBEEF);
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op = MDU_NONE;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("rst after", {31'd0, busy, hi}, 64'd0);
    chk("rst after lo", {32'd0, lo}, 64'd0);

    // Randomized ops against the reference model.
    for (int unsigned k = 0; k < 200; k++) begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ro = 4'($urandom_range(1, 8));
      ra = pick(10);
      rb = pick(15);
      model(ro, ra, rb, hi, lo, eh, el, ec);
      run_op($sformatf("rnd%0d op%0d", k, ro), ro, ra, rb, eh, el, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
